// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer.
// Handles MUL, UMULL, SMULL and UDIV over 32 shift/add (or restoring-divide)
// cycles, followed by one fix-up cycle and a one-cycle done pulse.
// Results use the two-word convention: result_hi is the primary result and
// result_lo is the secondary (low) word.
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo,
    output logic [3:0]  flags,
    output logic        div_by_zero
);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULL = 2'b01;
    localparam logic [1:0] OP_SMULL = 2'b10;
    localparam logic [1:0] OP_UDIV  = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic        sign_q;
    logic [63:0] mcand;    // multiplicand shifted left; low word holds the divisor for UDIV
    logic [31:0] mplier;   // multiplier shifted right; dividend/quotient for UDIV
    logic [63:0] acc;
    logic [32:0] rem;
    logic [4:0]  cnt;

    logic [32:0] rem_sh;
    logic [32:0] rem_diff;
    logic        q_bit;
    logic [63:0] prod;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;
    logic [3:0]  fix_flags;

    // Magnitude of a signed 32-bit value; 0x80000000 maps to itself, read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // Restoring-division trial subtract and fix-cycle result/flag formatting.
    always_comb begin
        rem_sh   = {rem[31:0], mplier[31]};
        rem_diff = rem_sh - {1'b0, mcand[31:0]};
        q_bit    = (rem_sh >= {1'b0, mcand[31:0]});

        prod = (op_q == OP_SMULL && sign_q) ? (~acc + 64'd1) : acc;

        fix_hi    = 32'd0;
        fix_lo    = 32'd0;
        fix_flags = 4'd0;
        case (op_q)
            OP_MUL: begin
                fix_hi = prod[31:0];
                fix_lo = 32'd0;
                fix_flags = {fix_hi[31], (fix_hi == 32'd0), 2'b00};
            end
            OP_UMULL, OP_SMULL: begin
                fix_hi = prod[63:32];
                fix_lo = prod[31:0];
                fix_flags = {fix_hi[31], (prod == 64'd0), 2'b00};
            end
            default: begin
                fix_hi = mplier;
                fix_lo = rem[31:0];
                fix_flags = {fix_hi[31], (fix_hi == 32'd0), 2'b00};
            end
        endcase
    end

    // Sequencer FSM: operand capture, iteration, fix-up and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            result_hi   <= 32'd0;
            result_lo   <= 32'd0;
            flags       <= 4'd0;
            op_q        <= 2'd0;
            sign_q      <= 1'b0;
            mcand       <= 64'd0;
            mplier      <= 32'd0;
            acc         <= 64'd0;
            rem         <= 33'd0;
            cnt         <= 5'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_q        <= op;
                        sign_q      <= (op == OP_SMULL) && (a[31] ^ b[31]);
                        acc         <= 64'd0;
                        rem         <= 33'd0;
                        cnt         <= 5'd0;
                        div_by_zero <= 1'b0;
                        if (op == OP_SMULL) begin
                            mcand  <= {32'd0, abs32(a)};
                            mplier <= abs32(b);
                        end else if (op == OP_UDIV) begin
                            mcand  <= {32'd0, b};
                            mplier <= a;
                        end else begin
                            mcand  <= {32'd0, a};
                            mplier <= b;
                        end
                        if (op == OP_UDIV && b == 32'd0) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            result_hi   <= 32'd0;
                            result_lo   <= a;
                            flags       <= 4'b0100;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                CALC: begin
                    if (op_q == OP_UDIV) begin
                        rem    <= q_bit ? rem_diff : rem_sh;
                        mplier <= {mplier[30:0], q_bit};
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= {mcand[62:0], 1'b0};
                        mplier <= {1'b0, mplier[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_hi <= fix_hi;
                    result_lo <= fix_lo;
                    flags     <= fix_flags;
                    state     <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: table of operations with hand-computed
// results, plus sequences for held start, back-to-back start, divide-by-zero
// hold and mid-operation reset.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
    logic [3:0]  flags;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    muldiv_seq dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .result_hi(result_hi),
        .result_lo(result_lo),
        .flags(flags),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  fl;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts one op, returns number of cycles after the start edge until done (0 = timeout).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int n);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        n = 1;
        while (!done && n < 60) begin
            if (busy && done) chk("busy_and_done", 1, 0);
            tick();
            n++;
        end
        if (!done) n = 0;
    endtask

    int n;
    int dones;

    initial begin
        vecs[0]  = '{2'b00, 32'd7,         32'd6,         32'h0000002A, 32'h0,        4'b0000, 1'b0, 34};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'h00000001, 4'b1000, 1'b0, 34};
        vecs[2]  = '{2'b10, 32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF, 32'hFFFFFFFA, 4'b1000, 1'b0, 34};
        vecs[3]  = '{2'b10, 32'h80000000,  32'h80000000,  32'h40000000, 32'h0,        4'b0000, 1'b0, 34};
        vecs[4]  = '{2'b10, 32'h0,         32'h80000000,  32'h0,        32'h0,        4'b0100, 1'b0, 34};
        vecs[5]  = '{2'b11, 32'd100,       32'd7,         32'd14,       32'd2,        4'b0000, 1'b0, 34};
        vecs[6]  = '{2'b11, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF, 32'h0,        4'b1000, 1'b0, 34};
        vecs[7]  = '{2'b00, 32'h00010000,  32'h00010000,  32'h0,        32'h0,        4'b0100, 1'b0, 34};
        vecs[8]  = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, 32'h0,        4'b0000, 1'b0, 34};
        vecs[9]  = '{2'b10, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, 1'b0, 34};
        vecs[10] = '{2'b11, 32'd7,         32'd100,       32'h0,        32'd7,        4'b0100, 1'b0, 34};
        vecs[11] = '{2'b11, 32'd5,         32'd0,         32'h0,        32'd5,        4'b0100, 1'b1, 1};

        reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_lo", result_lo, 0);
        chk("rst_flags", flags, 0);
        chk("rst_dbz", div_by_zero, 0);
        tick();

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            chk($sformatf("v%0d_latency", i), n, vecs[i].lat);
            chk($sformatf("v%0d_hi", i), result_hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), result_lo, vecs[i].lo);
            chk($sformatf("v%0d_flags", i), flags, vecs[i].fl);
            chk($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].dbz);
            chk($sformatf("v%0d_busy_at_done", i), busy, 0);
            tick();
            tick();
        end

        // Divide-by-zero results and flag hold while idle.
        repeat (5) tick();
        chk("dbz_hold", div_by_zero, 1);
        chk("dbz_hold_lo", result_lo, 5);
        chk("dbz_hold_done", done, 0);

        // Held start with changing operands: one MUL 3*5 only.
        op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
        tick();
        chk("held_busy", busy, 1);
        chk("held_dbz_cleared", div_by_zero, 0);
        n = 1;
        while (!done && n < 60) begin
            if (n < 20) begin
                a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk("held_latency", done ? n : 0, 34);
        chk("held_hi", result_hi, 15);
        chk("held_lo", result_lo, 0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dones++;
        end
        chk("held_single_op", dones, 0);

        // Back-to-back: start again in the DONE cycle.
        run_op(2'b01, 32'd2, 32'd3, n);
        chk("b2b_first_latency", n, 34);
        chk("b2b_first_lo", result_lo, 6);
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_done_low", done, 0);
        n = 1;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        chk("b2b_second_latency", done ? n : 0, 34);
        chk("b2b_second_hi", result_hi, 81);
        tick();

        // Reset during a UMULL aborts with no done pulse.
        op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("abort_busy_before", busy, 1);
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", result_hi, 0);
        chk("abort_lo", result_lo, 0);
        chk("abort_flags", flags, 0);
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done || busy) dones++;
        end
        chk("abort_no_done", dones, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the multi-cycle core. It takes the long-latency integer operations (MUL, UMULL, SMULL, UDIV) off the single-cycle ALU path and executes them over 34 cycles with a start/busy/done handshake. The main control FSM stalls on `busy` and writes back on `done`. Results follow the ALU's two-word convention: `result_hi` is the primary result and `result_lo` is the secondary (low) word.

## Interface
- Parameters: none; datapath width is fixed at 32 bits.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  2  00 MUL, 01 UMULL, 10 SMULL, 11 UDIV; sampled with `start`.
- `a`  in  32  first operand (multiplicand / dividend); sampled with `start`.
- `b`  in  32  second operand (multiplier / divisor); sampled with `start`.
- `busy`  out  1  high while an operation is in progress; new starts are ignored.
- `done`  out  1  one-cycle pulse; results and flags are valid this cycle.
- `result_hi`  out  32  MUL: product[31:0]; UMULL/SMULL: product[63:32]; UDIV: quotient.
- `result_lo`  out  32  MUL: 0; UMULL/SMULL: product[31:0]; UDIV: remainder.
- `flags`  out  4  {N,Z,C,V}.
- `div_by_zero`  out  1  set with `done` when a UDIV had `b`=0; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1:
  - Latch `op`.
  - Latch operands: for SMULL, latch |a| and |b| as unsigned 32-bit values, plus sign = a[31]^b[31]; otherwise latch raw values.
  - Clear the 64-bit accumulator and the 5-bit iteration counter.
  - Clear `div_by_zero`.
  - Next state is CALC, except UDIV with b=0, which goes straight to DONE.
- CALC, multiply (MUL/UMULL/SMULL): radix-2 shift-add, one multiplier bit per cycle, LSB first, 64-bit accumulator.
- CALC, UDIV: restoring division, one quotient bit per cycle, MSB first, 33-bit partial remainder.
- CALC length: exactly 32 cycles (counter 0..31); counter=31 → FIX.
- FIX (1 cycle):
  - SMULL with sign=1: 64-bit two's-complement negate of the product.
  - All ops: load `result_hi`/`result_lo` per the op mapping.
  - Compute flags.
  - → DONE.
- DONE (1 cycle): `done`=1, `busy`=0.
  - start=1 → accepted exactly as in IDLE; DONE goes directly to CALC, or to DONE for UDIV by zero.
  - Otherwise → IDLE.
- Divide by zero: `result_hi`=0, `result_lo`=a, `div_by_zero`=1, flags {0,1,0,0}.
- Flags:
  - N = result_hi[31].
  - Z = (result_hi==0) for MUL/UDIV; (result_hi==0 && result_lo==0) for UMULL/SMULL.
  - C = V = 0 always.
- `result_hi`, `result_lo`, `flags` and `div_by_zero` hold their values after DONE until the next FIX or divide-by-zero load.
- Operands are used only from the latched copies; `a`/`b`/`op` may change freely after the start cycle.
- SMULL with a or b = 0x80000000: magnitude 0x80000000 is handled as an unsigned value with no overflow.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`=0, `done`=0, `div_by_zero`=0.
  - `result_hi`=0, `result_lo`=0, `flags`=0.
  - Counter and accumulator = 0.
- Reset mid-operation:
  - Aborts at the next edge.
  - No `done` pulse.
  - All outputs take their reset values.
  - Reset has priority over `start`.
- Latency, normal path: start sampled at edge k → `busy` high from k+1 through k+33 (32 CALC cycles + FIX) → `done` high in cycle k+34 → back-to-back start accepted at edge k+34.
- Latency, divide by zero: `done` high in cycle k+1; `busy` never asserts.
- `start` while `busy`=1: ignored, no side effects; it is not queued.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- MUL a=7, b=6 → `done` exactly 34 cycles after start; result_hi=0x0000002A, result_lo=0, flags=0000.
- UMULL a=b=0xFFFFFFFF → result_hi=0xFFFFFFFE, result_lo=0x00000001, N=1, Z=0. Then SMULL a=0xFFFFFFFE (−2), b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA, N=1.
- SMULL a=b=0x80000000 → hi=0x40000000, lo=0, N=0, Z=0. SMULL a=0, b=0x80000000 → hi=lo=0, Z=1.
- UDIV 100/7 → hi=14, lo=2. UDIV 0xFFFFFFFF/1 → hi=0xFFFFFFFF, lo=0, N=1. UDIV 5/0 → `done` at cycle k+1, hi=0, lo=5, div_by_zero=1, Z=1.
- Hold `start`=1 with changing operands during `busy` → still a single operation on the latched operands. Start again in the DONE cycle → second `done` exactly 34 cycles later.
- Assert `reset` at cycle 10 of a UMULL → next cycle busy=0, done=0, results=0. No `done` pulse ever appears for the aborted operation.
